dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store handshake for the core.
// Illegal requests complete in one cycle with err; RAM is never reset.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_valid,
    input  logic        w_valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q;

    logic [31:0] mem [2**ADDR_W];

    logic              req;
    logic              legal;
    logic [ADDR_W-1:0] in_idx;
    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign req    = r_valid | w_valid;
    assign legal  = (r_valid ^ w_valid) && (addr[1:0] == 2'b00);
    assign in_idx = addr[ADDR_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        access    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && legal) begin
                    we_d    = w_valid;
                    idx_d   = in_idx;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    cnt_d   = CNT_INIT;
                    // Single-cycle latency: access straight from the inputs
                    if (LATENCY == 1) begin
                        state_d   = S_DONE;
                        access    = 1'b1;
                        acc_we    = w_valid;
                        acc_idx   = in_idx;
                        acc_wdata = wdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (req) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    access  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            if (access && !acc_we) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // Reset gates the write so an aborted store never lands
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign ready = (state_q == S_DONE);
    assign err   = ready && err_q;
    assign busy  = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);
    assign rdata = rdata_q;

endmodule
